loop_seeker: RTL
================

# loop_seeker

Bracket-matching controller for the BF core's loop instructions. On a `[` with a zero cell or a `]` with a nonzero cell, the execute stage hands control to this block. It then steps the program counter one instruction at a time, tracking nesting depth, until the matching bracket is reached. It sits directly upstream of the PC counter: its outputs drive that counter's `ce` and `down` inputs, and it consumes the instruction fetched at each new PC.

## Interface
- `DEPTH_WIDTH`, default 8: width of the nesting-depth register.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a seek; sampled only in IDLE.
- `dir`  in  1  seek direction, sampled with `start`: 0 = forward (from `[`), 1 = backward (from `]`).
- `insn`  in  8  instruction at the current PC.
- `insn_valid`  in  1  `insn` reflects the PC after the most recent step.
- `pc_ce`  out  1  PC counter step enable.
- `pc_down`  out  1  PC counter direction; equals the latched `dir` while `pc_ce` is high, else 0.
- `busy`  out  1  seek in progress.
- `done`  out  1  one-cycle pulse: PC now addresses the matching bracket.
- `err`  out  1  one-cycle pulse: seek aborted (only with the macro defined).

## Operation
- States:
  - IDLE: `busy`=0.
  - STEP: `pc_ce`=1 for exactly one cycle.
  - WAIT: holds until `insn_valid` is high.
  - DONE: `done`=1 for one cycle, then returns to IDLE.
  - ERR: `err`=1 for one cycle, then returns to IDLE.
- IDLE with `start`=1: latch `dir`, set depth to 1, go to STEP.
- STEP goes to WAIT unconditionally. `insn_valid` is ignored in STEP.
- WAIT with `insn_valid`=1, classifying `insn`:
  - Opening bracket = `[` if forward, `]` if backward. Closing bracket is the other one.
  - Opening bracket: depth+1, go to STEP.
  - Closing bracket with depth==1: go to DONE. The depth register is not decremented below 1.
  - Closing bracket with depth>1: depth-1, go to STEP.
  - Any other byte: go to STEP.
- Unsigned depth arithmetic, DEPTH_WIDTH bits.
- `start` while `busy`=1 is ignored.
- Reset asserted at any time, including mid-seek:
  - Go to IDLE and clear depth and the latched `dir`.
  - All outputs go to 0 immediately.
  - PC is left wherever the last completed step put it.
- `busy`=1 in STEP, WAIT, DONE and ERR.

## Timing
- Reset values: `pc_ce`=0, `pc_down`=0, `busy`=0, `done`=0, `err`=0.
- `start` sampled at edge E0 → STEP during the cycle after E0.
- Each PC step costs 1 cycle in STEP plus at least 1 cycle in WAIT.
- With single-cycle fetch (`insn_valid` in the cycle after `pc_ce`), a match N instructions away gives `done` 2N+1 cycles after the `start` edge.
- `pc_ce` is never asserted in WAIT, DONE or ERR. PC moves exactly N times per seek.
- The next `start` is accepted in the cycle after DONE or ERR.

## Configuration
- `LOOP_SEEKER_CHECK_EN` defined:
  - Abort to ERR on either of two conditions, seen in WAIT with `insn_valid`:
    - an opening bracket while depth equals all-ones (depth overflow);
    - `insn`==8'h00 (end-of-program marker, i.e. an unmatched bracket).
  - On abort, depth is not updated and `done` is not pulsed.
- Undefined:
  - Depth wraps modulo 2^DEPTH_WIDTH.
  - 8'h00 is treated as an ordinary byte.
  - `err` is tied to 0 and the ERR state is absent.

## Structure
- Shared package `bf_pkg` holds:
  - `BF_OPEN` = 8'h5B and `BF_CLOSE` = 8'h5D;
  - `BF_EOP` = 8'h00;
  - the state enum `seek_state_t` {IDLE, STEP, WAIT, DONE, ERR}.
- One natural sub-module: `loop_depth_counter`.
  - Up/down/preset depth register with asynchronous active-low reset.
  - Overflow flag present only under `LOOP_SEEKER_CHECK_EN`.

## Test plan
- Forward, program `[+-]` from PC 0, 1-cycle fetch: `start`, `dir`=0 → 3 `pc_ce` pulses, `pc_down`=0, `done` at cycle 7, PC=3.
- Backward nested, `[[-]>]` from PC 5: `dir`=1 → skips inner pair, `done` with PC=0 after 5 down-steps, depth back to 1.
- Slow fetch: `insn_valid` delayed 3 cycles per step → `pc_ce` never reasserted early, PC step count still exact.
- `start` pulsed while `busy` → ignored: no second seek, `dir` unchanged.
- Reset asserted in WAIT → all outputs 0 in the same cycle; after release `busy`=0, next `start` works normally.
- Macro defined, DEPTH_WIDTH=2, 4 nested `[`, or an 8'h00 during a forward seek → `err` pulse, no `done`, IDLE. Macro undefined, same stimulus → no `err`, depth wraps.

Source files
------------

// File: rtl/bf_pkg.sv
// bf_pkg: shared BF opcodes and loop-seek FSM states.
package bf_pkg;
  localparam logic [7:0] BF_OPEN  = 8'h5B;
  localparam logic [7:0] BF_CLOSE = 8'h5D;
  localparam logic [7:0] BF_EOP   = 8'h00;
  typedef enum logic [2:0] {IDLE, STEP, WAIT, DONE, ERR} seek_state_t;
  function automatic logic is_open(input logic [7:0] c, input logic backward);
    return c == (backward ? BF_CLOSE : BF_OPEN);
  endfunction
endpackage

// File: rtl/loop_seeker_if.sv
// loop_seeker_if: seek request, fetched instruction and PC-counter controls.
interface loop_seeker_if;
  logic       start;
  logic       dir;
  logic [7:0] insn;
  logic       insn_valid;
  logic       pc_ce;
  logic       pc_down;
  logic       busy;
  logic       done;
  logic       err;
  modport master (output start, dir, insn, insn_valid, input pc_ce, pc_down, busy, done, err);
  modport slave (input start, dir, insn, insn_valid, output pc_ce, pc_down, busy, done, err);
endinterface

// File: rtl/loop_depth_counter.sv
// loop_depth_counter: preset/up/down nesting depth; overflow flag under LOOP_SEEKER_CHECK_EN.
module loop_depth_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         preset,
  input  logic         inc,
  input  logic         dec,
`ifdef LOOP_SEEKER_CHECK_EN
  output logic         ovf,
`endif
  output logic [W-1:0] depth
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) depth <= '0;
    else if (preset) depth <= W'(1);
    else if (inc) depth <= depth + W'(1);
    else if (dec) depth <= depth - W'(1);
`ifdef LOOP_SEEKER_CHECK_EN
  assign ovf = &depth;
`endif
endmodule

// File: rtl/loop_seeker.sv
// loop_seeker: steps the PC to the matching bracket; LOOP_SEEKER_CHECK_EN adds overflow/EOP abort.
module loop_seeker
  import bf_pkg::*;
#(
  parameter int DEPTH_WIDTH = 8
) (
  input logic          clk,
  input logic          reset,
  loop_seeker_if.slave bus
);
  seek_state_t state, nxt;
  logic dir_q, open_c, close_c, one, ev, abort, preset;
  logic [DEPTH_WIDTH-1:0] depth;
`ifdef LOOP_SEEKER_CHECK_EN
  logic ovf;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      dir_q <= 1'b0;
    end else begin
      state <= nxt;
      if (preset) dir_q <= bus.dir;
    end
  assign preset  = state == IDLE && bus.start;
  assign ev      = state == WAIT && bus.insn_valid;
  assign open_c  = is_open(bus.insn, dir_q);
  assign close_c = is_open(bus.insn, !dir_q);
  assign one     = depth == DEPTH_WIDTH'(1);
`ifdef LOOP_SEEKER_CHECK_EN
  assign abort   = ev && (bus.insn == BF_EOP || (open_c && ovf));
`else
  assign abort   = 1'b0;
`endif
  // a closing bracket at depth 1 is the match, so depth never drops below 1 there
  loop_depth_counter #(.W(DEPTH_WIDTH)) u_depth (
    .clk(clk),
    .reset(reset),
    .preset(preset),
    .inc(ev && open_c && !abort),
    .dec(ev && close_c && !one),
`ifdef LOOP_SEEKER_CHECK_EN
    .ovf(ovf),
`endif
    .depth(depth)
  );
  always_comb begin
    nxt = IDLE;
    nxt = state == IDLE ? (bus.start ? STEP : IDLE) :
          state == STEP ? WAIT :
          state == WAIT ? (!bus.insn_valid ? WAIT : abort ? ERR : (close_c && one) ? DONE : STEP) :
          IDLE;
  end
  assign bus.pc_ce   = state == STEP;
  assign bus.pc_down = state == STEP && dir_q;
  assign bus.busy    = state != IDLE;
  assign bus.done    = state == DONE;
`ifdef LOOP_SEEKER_CHECK_EN
  assign bus.err     = state == ERR;
`else
  assign bus.err     = 1'b0;
`endif
endmodule
